// File: rtl/exe_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EXE stage.
// Produces {remainder, quotient} and holds the pipeline while a divide runs.
module exe_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               stall_req_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BY_ZERO,
    ON,
    END
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 dvd_neg;
  logic                 dvs_neg;
  logic [WIDTH-1:0]     abs_dvd;
  logic [WIDTH-1:0]     abs_dvs;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_step;
  logic [WIDTH-1:0]     quo_step;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     quo_fix;

  assign dvd_neg = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg = signed_i & divisor_i[WIDTH-1];
  assign abs_dvd = dvd_neg ? -dividend_i : dividend_i;
  assign abs_dvs = dvs_neg ? -divisor_i : divisor_i;

  // Shift next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_step = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end
    rem_fix = rneg_q ? -rem_step : rem_step;
    quo_fix = qneg_q ? -quo_step : quo_step;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (annul_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = abs_dvd;
            dvs_d    = abs_dvs;
            qneg_d   = dvd_neg ^ dvs_neg;
            rneg_d   = dvd_neg;
            result_d = '0;
            state_d  = (divisor_i == '0) ? BY_ZERO : ON;
          end
        end
        BY_ZERO: begin
          result_d = '0;
          state_d  = END;
        end
        ON: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = {rem_fix, quo_fix};
            state_d  = END;
          end
        end
        END: begin
          if (!start_i) begin
            state_d  = IDLE;
            result_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign ready_o     = (state_q == END);
  assign result_o    = result_q;
  assign stall_req_o = start_i & (state_q != END) & ~annul_i & ~rst;

endmodule

// File: tb/tb_exe_div_unit.sv
// Bench for exe_div_unit: random divides checked every cycle against
// an arithmetic model, plus directed corner cases.
module tb_exe_div_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i = 1'b0;
  logic           signed_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [W-1:0]   dividend_i = '0;
  logic [W-1:0]   divisor_i = '0;
  logic           stall_req_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;

  int tests = 0;
  int fails = 0;

  exe_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .annul_i     (annul_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .stall_req_o (stall_req_o),
    .ready_o     (ready_o),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_div(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic s
  );
    logic sa, sb;
    logic [W-1:0] ua, ub, q, r;
    if (b == '0) return '0;
    sa = s & a[W-1];
    sb = s & b[W-1];
    ua = sa ? (0 - a) : a;
    ub = sb ? (0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sa ^ sb) q = 0 - q;
    if (sa) r = 0 - r;
    return {r, q};
  endfunction

  // Model: a divide accepted from idle completes a fixed number of edges later.
  bit             m_busy = 0;
  bit             m_done = 0;
  int             m_left = 0;
  logic [2*W-1:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0;
      m_done <= 0;
      m_left <= 0;
      m_res  <= '0;
    end else if (annul_i) begin
      m_busy <= 0;
      m_done <= 0;
      m_res  <= '0;
    end else if (m_done) begin
      if (!start_i) begin
        m_done <= 0;
        m_res  <= '0;
      end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 0;
        m_done <= 1;
      end
    end else if (start_i) begin
      m_busy <= 1;
      m_res  <= ref_div(dividend_i, divisor_i, signed_i);
      m_left <= (divisor_i == '0) ? 1 : W;
    end
  end

  always @(negedge clk) begin
    logic           e_rdy, e_stall;
    logic [2*W-1:0] e_res;
    e_rdy   = m_done;
    e_res   = m_done ? m_res : '0;
    e_stall = start_i & ~m_done & ~annul_i & ~rst;
    tests++;
    if (ready_o !== e_rdy || stall_req_o !== e_stall || result_o !== e_res) begin
      fails++;
      $display("FAIL cycle_check t=%0t ready=%b/%b stall=%b/%b result=%h/%h (got/exp)",
               $time, ready_o, e_rdy, stall_req_o, e_stall, result_o, e_res);
    end
  end

  task automatic chk(input string name, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           s,
    input  int             hold,
    input  int             annul_at,
    input  bit             scramble,
    output int             lat,
    output logic [2*W-1:0] res,
    output bit             annulled
  );
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    lat        = -1;
    res        = '0;
    annulled   = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n - 1 == annul_at) begin
        annul_i = 1'b1;
        #1;
        chk("annul_stall", {63'b0, stall_req_o}, '0);
        step();
        annul_i  = 1'b0;
        start_i  = 1'b0;
        annulled = 1;
        chk("annul_ready", {63'b0, ready_o}, '0);
        repeat (3) step();
        return;
      end
      step();
      if (ready_o) begin
        lat = n;
        res = result_o;
        break;
      end
      if (scramble) begin
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'($urandom);
      end
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: ready_o not seen within 100 cycles");
    end
    repeat (hold) step();
    start_i = 1'b0;
    step();
    chk("drop_clear", {ready_o, result_o[62:0]}, '0);
  endtask

  initial begin
    int             lat;
    logic [2*W-1:0] res;
    bit             an;
    logic [W-1:0]   a, b;
    logic           s;

    rst = 1'b1;
    #1;
    chk("reset_result", result_o, '0);
    chk("reset_ready", {63'b0, ready_o}, '0);
    start_i = 1'b1;
    #1;
    chk("reset_stall", {63'b0, stall_req_o}, '0);
    start_i = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();

    chk("model_7_2", ref_div(32'd7, 32'd2, 1'b0), {32'h1, 32'h3});
    chk("model_m7_2", ref_div(32'hFFFFFFF9, 32'h2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model_7_m2", ref_div(32'd7, 32'hFFFFFFFE, 1'b1), {32'h1, 32'hFFFFFFFD});
    chk("model_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});
    chk("model_div0", ref_div(32'd5, 32'd0, 1'b0), '0);

    do_div(32'd7, 32'd2, 1'b0, 0, -1, 0, lat, res, an);
    chk("divu_7_2", res, {32'h1, 32'h3});
    chk("divu_lat", 64'(lat), 64'd33);
    do_div(32'hFFFFFFF9, 32'h2, 1'b1, 0, -1, 0, lat, res, an);
    chk("div_m7_2", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, 0, -1, 1, lat, res, an);
    chk("div_7_m2", res, {32'h1, 32'hFFFFFFFD});
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, -1, 0, lat, res, an);
    chk("div_ovf", res, {32'h0, 32'h80000000});
    do_div(32'hFFFFFFFF, 32'h1, 1'b0, 0, -1, 0, lat, res, an);
    chk("divu_max", res, {32'h0, 32'hFFFFFFFF});
    do_div(32'd5, 32'd0, 1'b0, 0, -1, 0, lat, res, an);
    chk("div0_res", res, '0);
    chk("div0_lat", 64'(lat), 64'd2);

    do_div(32'd50, 32'd3, 1'b0, 0, 10, 0, lat, res, an);
    do_div(32'd100, 32'd7, 1'b0, 0, -1, 0, lat, res, an);
    chk("after_annul", res, {32'd2, 32'd14});

    do_div(32'd11, 32'd4, 1'b0, 3, -1, 0, lat, res, an);
    chk("hold_res", res, {32'd3, 32'd2});

    // Asynchronous reset in the middle of a divide.
    dividend_i = 32'd1000;
    divisor_i  = 32'd9;
    signed_i   = 1'b0;
    start_i    = 1'b1;
    repeat (18) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_mid_stall", {63'b0, stall_req_o}, '0);
    chk("arst_mid_res", {ready_o, result_o[62:0]}, '0);
    start_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_div(32'd9, 32'd3, 1'b0, 0, -1, 0, lat, res, an);
    chk("after_arst", res, {32'd0, 32'd3});

    // Asynchronous reset while a finished result is being held.
    dividend_i = 32'd77;
    divisor_i  = 32'd5;
    start_i    = 1'b1;
    repeat (34) step();
    chk("end_hold_ready", {63'b0, ready_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_end_res", result_o, '0);
    chk("arst_end_ready", {63'b0, ready_o}, '0);
    start_i = 1'b0;
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 40; i++) begin
      int mode, hold, an_at;
      mode = $urandom_range(0, 9);
      a    = $urandom;
      s    = 1'($urandom);
      if (mode == 0)     b = '0;
      else if (mode < 4) b = W'($urandom_range(1, 15));
      else if (mode < 6) b = -W'($urandom_range(1, 15));
      else               b = $urandom;
      if (mode == 9) a = 32'h80000000;
      hold  = $urandom_range(0, 3);
      an_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 35) : -1;
      do_div(a, b, s, hold, an_at, 1'($urandom), lat, res, an);
      if (!an) begin
        chk("rand_res", res, ref_div(a, b, s));
        chk("rand_lat", 64'(lat), (b == '0) ? 64'd2 : 64'(W + 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
